// File: rtl/pmu_counter_bank_if.sv
// Register-access bus of the PMU counter bank: one request per cycle, and a response
// (rvalid/rdata/err) on the following cycle.
interface pmu_counter_bank_if;
   logic        cfg_req_i;
   logic        cfg_we_i;
   logic [11:0] cfg_addr_i;
   logic [31:0] cfg_wdata_i;
   logic        cfg_rvalid_o;
   logic [31:0] cfg_rdata_o;
   logic        cfg_err_o;

   modport master (
      output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o
   );

   modport slave (
      input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      output cfg_rvalid_o, cfg_rdata_o, cfg_err_o
   );
endinterface

// File: rtl/pmu_counter_bank.sv
// Event counter bank with a period timer, per-period budget throttling and a level IRQ.
// Define PMU_BANK_SNAPSHOT_EN to build the per-counter SNAP registers (captured at period start).
module pmu_counter_bank #(
   parameter int NUM_COUNTER    = 4,
   parameter int NUM_PORTS      = 2,
   parameter int EVENT_ID_WIDTH = 16,
   parameter int COUNTER_WIDTH  = 32
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [NUM_PORTS-1:0]                     evt_valid_i,
   input  logic [NUM_PORTS-1:0][EVENT_ID_WIDTH-1:0] evt_id_i,
   pmu_counter_bank_if.slave                        cfg,
   output logic [NUM_COUNTER-1:0]                   throttle_o,
   output logic                                     irq_o
);
   localparam int CW  = COUNTER_WIDTH;
   localparam int EW  = EVENT_ID_WIDTH;
   localparam int HW  = $clog2(NUM_PORTS + 1);
   localparam int CW1 = CW + 1;

   localparam logic [1:0] MODE_UP     = 2'd1;
   localparam logic [1:0] MODE_BUDGET = 2'd2;

   function automatic logic [HW-1:0] popcount(input logic [NUM_PORTS-1:0] v);
      logic [HW-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_PORTS; i++) c = c + HW'(v[i]);
      return c;
   endfunction

   function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a, input logic [HW-1:0] b);
      logic [CW-1:0] bw;
      bw = CW'(b);
      return (a > bw) ? (a - bw) : '0;
   endfunction

   logic [CW-1:0]          period_q, timer_q;
   logic [NUM_COUNTER-1:0] irq_status_q, irq_enable_q;
   logic [1:0]             mode_q    [NUM_COUNTER];
   logic [NUM_PORTS-1:0]   pmask_q   [NUM_COUNTER];
   logic [EW-1:0]          mval_q    [NUM_COUNTER];
   logic [EW-1:0]          mmask_q   [NUM_COUNTER];
   logic [CW-1:0]          budget_q  [NUM_COUNTER];
   logic [CW-1:0]          count_q   [NUM_COUNTER];
   logic [CW-1:0]          snap_val  [NUM_COUNTER];

   logic [11:0]            addr;
   logic [31:0]            wdata, rd_data;
   logic                   mapped, read_only, wr_ok, err_p0;
   logic                   wr_period, wr_status, wr_enable;
   logic [NUM_COUNTER-1:0] wr_ctrl, wr_match, wr_budget, wr_count, cnt_sel;
   logic                   period_start;

   logic [NUM_PORTS-1:0]   match_vec [NUM_COUNTER];
   logic [HW-1:0]          hits      [NUM_COUNTER];
   logic [CW1-1:0]         up_sum    [NUM_COUNTER];
   logic [CW-1:0]          count_nxt [NUM_COUNTER];
   logic [NUM_COUNTER-1:0] hw_set;

   logic                   rsp_vld_p1, rsp_err_p1;
   logic [31:0]            rsp_rdata_p1;
   logic                   unused_wdata;

   assign addr         = cfg.cfg_addr_i;
   assign wdata        = cfg.cfg_wdata_i;
   assign unused_wdata = ^wdata;

   // ---- p0: address decode and read mux ----
   always_comb begin
      rd_data   = '0;
      mapped    = 1'b0;
      read_only = 1'b0;
      case (addr)
         12'h000: begin mapped = 1'b1; rd_data = 32'(period_q); end
         12'h004: begin mapped = 1'b1; read_only = 1'b1; rd_data = 32'(timer_q); end
         12'h008: begin mapped = 1'b1; rd_data = 32'(irq_status_q); end
         12'h00C: begin mapped = 1'b1; rd_data = 32'(irq_enable_q); end
         default: ;
      endcase
      for (int n = 0; n < NUM_COUNTER; n++) begin
         if (addr[11:5] == 7'(n + 1)) begin
            case (addr[4:0])
               5'h00: begin mapped = 1'b1; rd_data = 32'(mode_q[n]) | (32'(pmask_q[n]) << 8); end
               5'h04: begin mapped = 1'b1; rd_data = 32'(mval_q[n]) | (32'(mmask_q[n]) << 16); end
               5'h08: begin mapped = 1'b1; rd_data = 32'(budget_q[n]); end
               5'h0C: begin mapped = 1'b1; rd_data = 32'(count_q[n]); end
               5'h10: begin mapped = 1'b1; read_only = 1'b1; rd_data = 32'(snap_val[n]); end
               default: ;
            endcase
         end
      end
   end

   assign wr_ok     = cfg.cfg_req_i & cfg.cfg_we_i & mapped & ~read_only;
   assign err_p0    = cfg.cfg_req_i & (~mapped | (cfg.cfg_we_i & read_only));
   assign wr_period = wr_ok & (addr == 12'h000);
   assign wr_status = wr_ok & (addr == 12'h008);
   assign wr_enable = wr_ok & (addr == 12'h00C);

   always_comb begin
      cnt_sel   = '0;
      wr_ctrl   = '0;
      wr_match  = '0;
      wr_budget = '0;
      wr_count  = '0;
      for (int n = 0; n < NUM_COUNTER; n++) begin
         cnt_sel[n]   = (addr[11:5] == 7'(n + 1));
         wr_ctrl[n]   = wr_ok & cnt_sel[n] & (addr[4:0] == 5'h00);
         wr_match[n]  = wr_ok & cnt_sel[n] & (addr[4:0] == 5'h04);
         wr_budget[n] = wr_ok & cnt_sel[n] & (addr[4:0] == 5'h08);
         wr_count[n]  = wr_ok & cnt_sel[n] & (addr[4:0] == 5'h0C);
      end
   end

   // A PERIOD write restarts the timer, so it suppresses the wrap of that cycle.
   assign period_start = (period_q != '0) && (timer_q == period_q - CW'(1)) && !wr_period;

   always_comb begin
      for (int n = 0; n < NUM_COUNTER; n++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            match_vec[n][p] = evt_valid_i[p] & pmask_q[n][p] &
                              ((evt_id_i[p] & mmask_q[n]) == mval_q[n]);
         end
         hits[n] = popcount(match_vec[n]);
      end
   end

   // Priority: software write, then period reload, then event hits.
   always_comb begin
      hw_set = '0;
      for (int n = 0; n < NUM_COUNTER; n++) begin
         up_sum[n]    = {1'b0, count_q[n]} + CW1'(hits[n]);
         count_nxt[n] = count_q[n];
         if (wr_count[n]) begin
            count_nxt[n] = wdata[CW-1:0];
         end else if (mode_q[n] == MODE_BUDGET && period_start) begin
            count_nxt[n] = budget_q[n];
            hw_set[n]    = (count_q[n] != '0) && (budget_q[n] == '0);
         end else if (mode_q[n] == MODE_UP) begin
            count_nxt[n] = up_sum[n][CW-1:0];
            hw_set[n]    = up_sum[n][CW];
         end else if (mode_q[n] == MODE_BUDGET) begin
            count_nxt[n] = sat_sub(count_q[n], hits[n]);
            hw_set[n]    = (count_q[n] != '0) && (count_nxt[n] == '0);
         end
      end
   end

   // ---- p1: state update and registered outputs ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         period_q     <= '0;
         timer_q      <= '0;
         irq_status_q <= '0;
         irq_enable_q <= '0;
         irq_o        <= 1'b0;
         throttle_o   <= '0;
      end else begin
         if (wr_period) begin
            period_q <= wdata[CW-1:0];
            timer_q  <= '0;
         end else if (period_start || period_q == '0) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + CW'(1);
         end
         if (wr_enable) irq_enable_q <= wdata[NUM_COUNTER-1:0];
         // Hardware set is OR-ed after the W1C mask so a simultaneous set wins.
         irq_status_q <= (wr_status ? (irq_status_q & ~wdata[NUM_COUNTER-1:0]) : irq_status_q) | hw_set;
         irq_o        <= |(irq_status_q & irq_enable_q);
         for (int n = 0; n < NUM_COUNTER; n++)
            throttle_o[n] <= (mode_q[n] == MODE_BUDGET) && (count_q[n] == '0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int n = 0; n < NUM_COUNTER; n++) begin
            mode_q[n]   <= '0;
            pmask_q[n]  <= '0;
            mval_q[n]   <= '0;
            mmask_q[n]  <= '0;
            budget_q[n] <= '0;
            count_q[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_COUNTER; n++) begin
            if (wr_ctrl[n]) begin
               mode_q[n]  <= wdata[1:0];
               pmask_q[n] <= wdata[8 +: NUM_PORTS];
            end
            if (wr_match[n]) begin
               mval_q[n]  <= wdata[0 +: EW];
               mmask_q[n] <= wdata[16 +: EW];
            end
            if (wr_budget[n]) budget_q[n] <= wdata[CW-1:0];
            count_q[n] <= count_nxt[n];
         end
      end
   end

`ifdef PMU_BANK_SNAPSHOT_EN
   logic [CW-1:0] snap_q [NUM_COUNTER];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int n = 0; n < NUM_COUNTER; n++) snap_q[n] <= '0;
      end else if (period_start) begin
         for (int n = 0; n < NUM_COUNTER; n++) snap_q[n] <= count_q[n];
      end
   end

   always_comb begin
      for (int n = 0; n < NUM_COUNTER; n++) snap_val[n] = snap_q[n];
   end
`else
   always_comb begin
      for (int n = 0; n < NUM_COUNTER; n++) snap_val[n] = '0;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_vld_p1   <= 1'b0;
         rsp_err_p1   <= 1'b0;
         rsp_rdata_p1 <= '0;
      end else begin
         rsp_vld_p1   <= cfg.cfg_req_i;
         rsp_err_p1   <= err_p0;
         rsp_rdata_p1 <= (cfg.cfg_req_i && !cfg.cfg_we_i && mapped) ? rd_data : '0;
      end
   end

   assign cfg.cfg_rvalid_o = rsp_vld_p1;
   assign cfg.cfg_err_o    = rsp_err_p1;
   assign cfg.cfg_rdata_o  = rsp_rdata_p1;
endmodule

// File: tb/tb_pmu_counter_bank.sv
// Bench for pmu_counter_bank: register table, timer, counting modes, IRQ and reset sequences.
module tb_pmu_counter_bank;
   localparam int NC = 4;
   localparam int NP = 2;
   localparam int EW = 16;
   localparam int CW = 32;

`ifdef PMU_BANK_SNAPSHOT_EN
   localparam logic [31:0] SNAP_EXP = 32'd3;
`else
   localparam logic [31:0] SNAP_EXP = 32'd0;
`endif

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [NP-1:0]         evt_valid;
   logic [NP-1:0][EW-1:0] evt_id;
   logic [NC-1:0]         throttle;
   logic                  irq;

   pmu_counter_bank_if cfg_if ();

   pmu_counter_bank #(
      .NUM_COUNTER(NC), .NUM_PORTS(NP), .EVENT_ID_WIDTH(EW), .COUNTER_WIDTH(CW)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .evt_valid_i(evt_valid),
      .evt_id_i   (evt_id),
      .cfg        (cfg_if),
      .throttle_o (throttle),
      .irq_o      (irq)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] timer_a [9];
   logic [31:0] timer_b [4];

   task automatic chk(input string what, input logic [11:0] a, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s @0x%03h: got 0x%08h, expected 0x%08h", what, a, act, want);
      end
   endtask

   // Response scoreboard
   always @(negedge clk_i) begin
      if (rst_ni && cfg_if.cfg_rvalid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 12'hFFF, 32'(cfg_if.cfg_rvalid_o), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata", e.addr, cfg_if.cfg_rdata_o, e.rdata);
            chk("err", e.addr, 32'(cfg_if.cfg_err_o), 32'(e.err));
         end
      end
   end

   task automatic access(input logic we, input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
      cfg_if.cfg_req_i   = 1'b1;
      cfg_if.cfg_we_i    = we;
      cfg_if.cfg_addr_i  = a;
      cfg_if.cfg_wdata_i = d;
      exp_q.push_back({a, exp_rd, exp_err});
      @(posedge clk_i); #1;
      cfg_if.cfg_req_i = 1'b0;
      cfg_if.cfg_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      access(1'b1, a, d, 32'd0, 1'b0);
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] e);
      access(1'b0, a, 32'd0, e, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic set_evt(input logic [NP-1:0] v, input logic [EW-1:0] id0, input logic [EW-1:0] id1);
      evt_valid = v;
      evt_id[0] = id0;
      evt_id[1] = id1;
   endtask

   task automatic add(input logic we, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] r, input logic e);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.rdata = r; v.err = e;
      tbl.push_back(v);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      add(0, 12'h000, 0, 32'h0, 0);            // reset values
      add(0, 12'h004, 0, 32'h0, 0);
      add(0, 12'h008, 0, 32'h0, 0);
      add(0, 12'h00C, 0, 32'h0, 0);
      add(0, 12'h020, 0, 32'h0, 0);
      add(0, 12'h02C, 0, 32'h0, 0);
      add(0, 12'h030, 0, 32'h0, 0);
      add(0, 12'hFFC, 0, 32'h0, 1);            // unmapped
      add(0, 12'h010, 0, 32'h0, 1);
      add(1, 12'h004, 32'h1234, 32'h0, 1);     // RO write
      add(0, 12'h004, 0, 32'h0, 0);
      add(1, 12'h030, 32'h5, 32'h0, 1);
      add(0, 12'h030, 0, 32'h0, 0);
      add(1, 12'h020, 32'hFFFF_FFFF, 32'h0, 0);
      add(0, 12'h020, 0, 32'h0000_0303, 0);    // mode + 2-bit port mask
      add(1, 12'h024, 32'hFFFF_FFFF, 32'h0, 0);
      add(0, 12'h024, 0, 32'hFFFF_FFFF, 0);
      add(1, 12'h024, 32'h00AB_0012, 32'h0, 0);
      add(0, 12'h024, 0, 32'h00AB_0012, 0);
      add(0, 12'h0A0, 0, 32'h0, 1);            // counter 4 does not exist
      add(1, 12'h0A0, 32'h1, 32'h0, 1);
      add(0, 12'h034, 0, 32'h0, 1);
      add(0, 12'h001, 0, 32'h0, 1);
      add(1, 12'h00C, 32'hFFFF_FFFF, 32'h0, 0);
      add(0, 12'h00C, 0, 32'h0000_000F, 0);
      add(1, 12'h00C, 32'h0, 32'h0, 0);
      add(1, 12'h020, 32'h0, 32'h0, 0);
      add(0, 12'h020, 0, 32'h0, 0);
      add(1, 12'h068, 32'h0000_DEAD, 32'h0, 0);
      add(0, 12'h068, 0, 32'h0000_DEAD, 0);
      add(0, 12'h08C, 0, 32'h0, 0);
      timer_a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1, 32'd2, 32'd3};
      timer_b = '{32'd0, 32'd1, 32'd2, 32'd0};

      rst_ni = 1'b0;
      set_evt(2'b00, 16'h0, 16'h0);
      cfg_if.cfg_req_i = 1'b0; cfg_if.cfg_we_i = 1'b0;
      cfg_if.cfg_addr_i = 12'h0; cfg_if.cfg_wdata_i = 32'h0;
      #12;
      chk("rst_rvalid", 12'h0, 32'(cfg_if.cfg_rvalid_o), 32'd0);
      chk("rst_err", 12'h0, 32'(cfg_if.cfg_err_o), 32'd0);
      chk("rst_throttle", 12'h0, 32'(throttle), 32'd0);
      chk("rst_irq", 12'h0, 32'(irq), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err);

      // Timer wrap and PERIOD rewrite
      wr(12'h000, 32'd5);
      for (int i = 0; i < 9; i++) rd(12'h004, timer_a[i]);
      wr(12'h000, 32'd3);
      for (int i = 0; i < 4; i++) rd(12'h004, timer_b[i]);
      wr(12'h000, 32'd0);
      rd(12'h004, 32'd0);

      // Up counting with two ports
      wr(12'h024, 32'hFFFF_0012);
      wr(12'h020, 32'h0000_0301);
      set_evt(2'b11, 16'h12, 16'h12);
      idle(3);
      set_evt(2'b00, 16'h0, 16'h0);
      rd(12'h02C, 32'd6);
      set_evt(2'b11, 16'h12, 16'h13);
      idle(1);
      set_evt(2'b10, 16'h99, 16'h12);
      idle(1);
      set_evt(2'b00, 16'h0, 16'h0);
      rd(12'h02C, 32'd8);

      // Wrap raises IRQ
      wr(12'h00C, 32'h1);
      wr(12'h02C, 32'hFFFF_FFFF);
      chk("irq_before_wrap", 12'h0, 32'(irq), 32'd0);
      set_evt(2'b01, 16'h12, 16'h0);
      idle(1);
      set_evt(2'b00, 16'h0, 16'h0);
      rd(12'h02C, 32'd0);
      rd(12'h008, 32'd1);
      chk("irq_after_wrap", 12'h0, 32'(irq), 32'd1);
      wr(12'h008, 32'h1);
      idle(1);
      chk("irq_after_w1c", 12'h0, 32'(irq), 32'd0);

      // Same-cycle collisions
      set_evt(2'b01, 16'h12, 16'h0);
      wr(12'h02C, 32'd7);
      set_evt(2'b00, 16'h0, 16'h0);
      rd(12'h02C, 32'd7);
      wr(12'h02C, 32'hFFFF_FFFF);
      set_evt(2'b01, 16'h12, 16'h0);
      wr(12'h008, 32'h1);
      set_evt(2'b00, 16'h0, 16'h0);
      rd(12'h008, 32'd1);
      wr(12'h008, 32'h1);
      rd(12'h008, 32'd0);

      // Budget mode with period reload
      wr(12'h020, 32'h0000_0302);
      wr(12'h028, 32'd3);
      wr(12'h02C, 32'd0);
      wr(12'h000, 32'd20);
      chk("throttle_empty", 12'h0, 32'(throttle[0]), 32'd1);
      idle(20);
      set_evt(2'b11, 16'h12, 16'h12);
      rd(12'h02C, 32'd3);
      rd(12'h02C, 32'd1);
      set_evt(2'b00, 16'h0, 16'h0);
      rd(12'h02C, 32'd0);
      chk("throttle_spent", 12'h0, 32'(throttle[0]), 32'd1);
      rd(12'h008, 32'd1);
      idle(14);
      chk("throttle_hold", 12'h0, 32'(throttle[0]), 32'd1);
      idle(2);
      rd(12'h02C, 32'd3);
      chk("throttle_reload", 12'h0, 32'(throttle[0]), 32'd0);

      // Snapshot of pre-reload COUNT
      wr(12'h000, 32'd0);
      wr(12'h028, 32'd5);
      wr(12'h02C, 32'd5);
      wr(12'h000, 32'd10);
      set_evt(2'b11, 16'h12, 16'h12);
      idle(1);
      set_evt(2'b00, 16'h0, 16'h0);
      idle(9);
      rd(12'h030, SNAP_EXP);
      rd(12'h02C, 32'd5);
      wr(12'h000, 32'd0);

      // Asynchronous reset during an access
      wr(12'h02C, 32'd0);
      idle(1);
      chk("pre_rst_throttle", 12'h0, 32'(throttle[0]), 32'd1);
      chk("pre_rst_irq", 12'h0, 32'(irq), 32'd1);
      cfg_if.cfg_req_i = 1'b1; cfg_if.cfg_we_i = 1'b0; cfg_if.cfg_addr_i = 12'h02C;
      @(posedge clk_i); #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_rvalid", 12'h02C, 32'(cfg_if.cfg_rvalid_o), 32'd0);
      chk("rst_mid_throttle", 12'h0, 32'(throttle), 32'd0);
      chk("rst_mid_irq", 12'h0, 32'(irq), 32'd0);
      cfg_if.cfg_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      rd(12'h02C, 32'd0);
      rd(12'h020, 32'd0);
      rd(12'h00C, 32'd0);
      rd(12'h008, 32'd0);
      idle(2);
      chk("pending_rsp", 12'h0, 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
